// File: rtl/mpy_seq.sv
// Sequential 16x16 shift-add multiplier with signed/unsigned modes.
// One add step per cycle for 16 cycles, a sign-fix cycle, then a one-cycle done pulse.
module mpy_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] control_signal,
    input  logic [15:0] acc_in,
    input  logic [15:0] br_in,
    output logic [15:0] mr_data,
    output logic [15:0] acc_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ClearBit  = 21;
    localparam int unsigned StartBit  = 22;
    localparam int unsigned SignedBit = 23;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [31:0] prod_q, prod_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mr_q, mr_d;
    logic [15:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        ctl_clear;
    logic        ctl_start;
    logic        ctl_signed;
    logic [15:0] acc_mag;
    logic [15:0] br_mag;
    logic [31:0] addend;
    logic [31:0] fixed_prod;

    // Remaining control bits belong to other CPU units.
    logic unused_ctrl;
    assign unused_ctrl = ^{control_signal[31:24], control_signal[20:0]};

    assign ctl_clear  = control_signal[ClearBit];
    assign ctl_start  = control_signal[StartBit];
    assign ctl_signed = control_signal[SignedBit];

    // 16-bit magnitude; 0x8000 wraps to itself, which is its true unsigned magnitude.
    assign acc_mag = acc_in[15] ? (16'd0 - acc_in) : acc_in;
    assign br_mag  = br_in[15]  ? (16'd0 - br_in)  : br_in;

    assign addend     = {16'd0, mcand_q} << cnt_q;
    assign fixed_prod = neg_q ? (32'd0 - prod_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        mr_d     = mr_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ctl_start) begin
                    mcand_d  = ctl_signed ? acc_mag : acc_in;
                    mplier_d = ctl_signed ? br_mag : br_in;
                    neg_d    = ctl_signed & (acc_in[15] ^ br_in[15]);
                    prod_d   = 32'd0;
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[cnt_q]) begin
                    prod_d = prod_q + addend;
                end
                cnt_d  = cnt_q + 4'd1;
                busy_d = 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                prod_d  = fixed_prod;
                mr_d    = fixed_prod[31:16];
                lo_d    = fixed_prod[15:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Clear wins over everything else, including a start in the same cycle.
        if (ctl_clear) begin
            state_d  = StIdle;
            mcand_d  = 16'd0;
            mplier_d = 16'd0;
            neg_d    = 1'b0;
            prod_d   = 32'd0;
            cnt_d    = 4'd0;
            mr_d     = 16'd0;
            lo_d     = 16'd0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            neg_q    <= 1'b0;
            prod_q   <= 32'd0;
            cnt_q    <= 4'd0;
            mr_q     <= 16'd0;
            lo_q     <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            mr_q     <= mr_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mr_data  = mr_q;
    assign acc_data = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mpy_seq.sv
// Directed bench for mpy_seq: table of products plus hand-written
// retrigger, clear, reset and priority sequences.
module tb_mpy_seq;

    logic        clk;
    logic        rst;
    logic [31:0] control_signal;
    logic [15:0] acc_in;
    logic [15:0] br_in;
    logic [15:0] mr_data;
    logic [15:0] acc_data;
    logic        busy;
    logic        done;

    int n_vec;
    int n_bad;

    mpy_seq dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .acc_in         (acc_in),
        .br_in          (br_in),
        .mr_data        (mr_data),
        .acc_data       (acc_data),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic        noise;
        logic [15:0] mr;
        logic [15:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start, take edge E0, then scramble the operands.
    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic noise, input string name);
        logic [31:0] c;
        c     = noise ? 32'hFF1F_FFFF : 32'h0;
        c[21] = 1'b0;
        c[22] = 1'b1;
        c[23] = sgn;
        control_signal = c;
        acc_in = a;
        br_in  = b;
        tick();
        control_signal = 32'h0;
        acc_in = ~a;
        br_in  = b ^ 16'h5A5A;
        chk({name, " busy@E0"}, {31'd0, busy}, 32'd1);
    endtask

    // Step edges first..last (relative to E0) and check busy/done/result.
    task automatic track(input int first, input int last, input int done_edge,
                         input logic [15:0] emr, input logic [15:0] elo, input string name);
        for (int e = first; e <= last; e++) begin
            tick();
            chk($sformatf("%s busy@E%0d", name, e), {31'd0, busy},
                {31'd0, (e < done_edge)});
            chk($sformatf("%s done@E%0d", name, e), {31'd0, done},
                {31'd0, (e == done_edge)});
            if (e >= done_edge) begin
                chk($sformatf("%s mr@E%0d", name, e), {16'd0, mr_data}, {16'd0, emr});
                chk($sformatf("%s acc@E%0d", name, e), {16'd0, acc_data}, {16'd0, elo});
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " busy"}, {31'd0, busy}, 32'd0);
        chk({name, " done"}, {31'd0, done}, 32'd0);
        chk({name, " mr"}, {16'd0, mr_data}, 32'd0);
        chk({name, " acc"}, {16'd0, acc_data}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //            a         b         sgn   noise mr        lo
        vecs[0]  = '{16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h000F};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 16'h0001};
        vecs[2]  = '{16'hFFFE, 16'h0003, 1'b1, 1'b0, 16'hFFFF, 16'hFFFA};
        vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h4000, 16'h0000};
        vecs[4]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5]  = '{16'h8000, 16'h0002, 1'b0, 1'b0, 16'h0001, 16'h0000};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0001};
        vecs[7]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 16'hC000, 16'h8000};
        vecs[8]  = '{16'h00FF, 16'h0100, 1'b0, 1'b1, 16'h0000, 16'hFF00};
        vecs[9]  = '{16'h0005, 16'hFFFD, 1'b1, 1'b1, 16'hFFFF, 16'hFFF1};
        vecs[10] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0626, 16'h0060};
        vecs[11] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h4000, 16'h0000};

        rst = 1'b1;
        control_signal = 32'h0;
        acc_in = 16'h0;
        br_in  = 16'h0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].noise, $sformatf("v%0d", i));
            track(1, 18, 17, vecs[i].mr, vecs[i].lo, $sformatf("v%0d", i));
            tick();
        end

        // Start re-asserted at E5 with new operands is ignored.
        launch(16'h0003, 16'h0005, 1'b0, 1'b0, "retrig");
        track(1, 4, 17, 16'h0000, 16'h000F, "retrig");
        control_signal = 32'h00C0_0000;
        acc_in = 16'hAAAA;
        br_in  = 16'h5555;
        track(5, 5, 17, 16'h0000, 16'h000F, "retrig");
        control_signal = 32'h0;
        track(6, 18, 17, 16'h0000, 16'h000F, "retrig");

        // Clear at E8 mid-calc, restart at E9 completes 17 edges later (E26).
        launch(16'h1234, 16'h5678, 1'b0, 1'b0, "clr");
        track(1, 7, 17, 16'h0000, 16'h000F, "clr");
        control_signal = 32'h0020_0000;
        tick();
        chk_zero("clr@E8");
        launch(16'h00FF, 16'h0100, 1'b0, 1'b0, "clr_re");
        track(1, 18, 17, 16'h0000, 16'hFF00, "clr_re");

        // Reset at E10 mid-calc, restart at E11.
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "rst");
        track(1, 9, 17, 16'h0000, 16'hFF00, "rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst@E10");
        launch(16'hFFFE, 16'h0003, 1'b1, 1'b0, "rst_re");
        track(1, 18, 17, 16'hFFFF, 16'hFFFA, "rst_re");

        // Reset beats start; clear beats start.
        rst = 1'b1;
        control_signal = 32'h0040_0000;
        acc_in = 16'h0003;
        br_in  = 16'h0005;
        tick();
        rst = 1'b0;
        control_signal = 32'h0;
        chk_zero("rst+start");
        tick();
        chk_zero("rst+start+1");
        launch(16'h0003, 16'h0005, 1'b0, 1'b0, "pre_clr");
        track(1, 18, 17, 16'h0000, 16'h000F, "pre_clr");
        control_signal = 32'h0060_0000;
        tick();
        control_signal = 32'h0;
        chk_zero("clr+start");
        tick();
        chk_zero("clr+start+1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mpy_seq.md
MPY_SEQ -- requirements
Module: mpy_seq

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: synchronous, active-high reset, sampled on the `clk` rising edge.
REQ-003 SHALL have `control_signal`, input, 32 bits: CPU control word. Bits used here:
- [21] clear
- [22] start multiply
- [23] signed mode (1 = two's-complement, 0 = unsigned)
REQ-004 SHALL have `acc_in`, input, 16 bits: multiplicand, taken from ACC.
REQ-005 SHALL have `br_in`, input, 16 bits: multiplier, taken from BR.
REQ-006 SHALL have `mr_data`, output, 16 bits: product high half; drives the MR register `mr_in` port.
REQ-007 SHALL have `acc_data`, output, 16 bits: product low half; drives the ACC load path.
REQ-008 SHALL have `busy`, output, 1 bit: multiply in progress.
REQ-009 SHALL have `done`, output, 1 bit: one-cycle pulse, result valid.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, FIX, DONE; all outputs registered.
REQ-011 In IDLE with [22]=1 and [21]=0, SHALL at that edge:
- latch `acc_in`, `br_in` and [23];
- clear the 32-bit partial product;
- set the bit counter to 0;
- go to CALC.
REQ-012 In signed mode, SHALL latch operand magnitudes (absolute values as 16-bit unsigned; 0x8000 gives 0x8000) plus the sign XOR; in unsigned mode operands are latched as-is and the sign XOR is 0.
REQ-013 CALC SHALL do one shift-add step per cycle for exactly 16 cycles (counter 0..15):
- add the shifted multiplicand when the current multiplier bit is 1;
- use 32-bit arithmetic with no overflow loss;
- go to FIX after count 15.
REQ-014 FIX SHALL take one cycle: two's-complement-negate the 32-bit product if the sign XOR is 1, otherwise pass it through; then go to DONE.
REQ-015 On entry to DONE, SHALL load `mr_data` = product[31:16] and `acc_data` = product[15:0], and assert `done` for exactly one cycle; DONE then returns to IDLE unconditionally.
REQ-016 Latency: with start sampled at edge E0, results and `done` SHALL be visible after edge E17; `done` falls after E18.
REQ-017 `busy` SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-018 Start ([22]) SHALL be ignored in CALC, FIX and DONE; there is no queueing.
REQ-019 Operand changes on `acc_in`/`br_in` after the start edge SHALL NOT affect the result.
REQ-020 `mr_data`/`acc_data` SHALL hold the last result until the next DONE, clear, or reset.
REQ-021 Clear ([21]=1) in any state SHALL:
- zero `mr_data`, `acc_data`, `busy`, `done` and the internal registers;
- force IDLE at that edge;
- take priority over start ([21] and [22] both 1 gives clear only, no start).
REQ-022 Control bits other than [21], [22], [23] SHALL be ignored.

Reset
REQ-023 `rst`=1 at a rising edge SHALL force IDLE and zero all outputs and internal registers (`mr_data`=0x0000, `acc_data`=0x0000, `busy`=0, `done`=0), in any state including mid-CALC.
REQ-024 `rst` SHALL take priority over clear and start; the first start is accepted at the first edge with `rst`=0.
REQ-025 No logic SHALL depend on initial-value assignments; all state SHALL be set by `rst`.

Verification
REQ-026 Unsigned 0x0003 x 0x0005, start at E0 -> after E17: `mr_data`=0x0000, `acc_data`=0x000F, `done`=1 for one cycle.
REQ-027 Unsigned 0xFFFF x 0xFFFF -> `mr_data`=0xFFFE, `acc_data`=0x0001.
REQ-028 Signed (-2 x 3):
- 0xFFFE x 0x0003 -> `mr_data`=0xFFFF, `acc_data`=0xFFFA.
- Signed 0x8000 x 0x8000 -> `mr_data`=0x4000, `acc_data`=0x0000.
REQ-029 Start re-asserted at E5 with new operands -> ignored; the E0 result appears after E17 unchanged; `busy`=1 from E1 through E16 inclusive.
REQ-030 Clear at E8 mid-CALC:
- after E8: `busy`=0, outputs 0x0000, no `done` at E17;
- a new start at E9 completes after E26.
REQ-031 `rst` at E10 mid-CALC -> all outputs 0 after E10; the previous result is lost; a start at E11 is accepted normally.
